// File: rtl/u_dmem_pkg.sv
// u_dmem_pkg
//   Shared types and constants for the u_dmem data-memory responder.
//   - dmem_st_e : responder FSM states
//   - LAT_W     : width of the wait-state counter (supports LAT 0..15)
//   - NLANE     : number of byte lanes in a 32-bit word
//   - lane_mask : expands a per-lane enable into a 32-bit bit mask
package u_dmem_pkg;

  localparam int LAT_W = 4;
  localparam int NLANE = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_st_e;

  function automatic logic [31:0] lane_mask(input logic [NLANE-1:0] en);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NLANE; i++) begin
      m[8*i +: 8] = {8{en[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/u_dmem_ram.sv
// u_dmem_ram
//   Single-port DEPTH x 32 synchronous RAM with byte write enables and a
//   registered read port. On an enabled cycle the read register returns
//   the word as it looks after this cycle's write (write-first).
//   Ports:
//     clk   - clock
//     rstn  - async active-low reset (clears the read register only)
//     en    - access enable
//     addr  - word index
//     we    - per-lane write enables
//     wd    - write data
//     rd    - registered read data
module u_dmem_ram
  import u_dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [NLANE-1:0] we,
  input  logic [31:0]      wd,
  output logic [31:0]      rd
);

  logic [31:0] mem [DEPTH];

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NLANE; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  // Written lanes are forwarded so a combined write+read sees the new word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd <= '0;
    end else if (en) begin
      for (int i = 0; i < NLANE; i++) begin
        rd[8*i +: 8] <= we[i] ? wd[8*i +: 8] : mem[addr][8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/u_dmem.sv
// u_dmem
//   Data-memory responder for the LSU port. Accepts a word-addressed
//   load/store request, waits LAT cycles, commits the write, and returns a
//   one-cycle lsu_vld pulse with lane-masked read data.
//   Optional feature macro: DMEM_ERR_EN adds lsu_err (out-of-range or
//   misaligned request; misaligned writes are suppressed).
//   Ports:
//     clk, rstn  - clock, async active-low reset
//     lsu_a      - byte address (word index = lsu_a[AW+1:2])
//     lsu_we     - byte write enables
//     lsu_wd     - write data
//     lsu_re     - byte read enables
//     lsu_vld    - response pulse
//     lsu_rd     - read data, valid with lsu_vld
//     lsu_err    - error flag with lsu_vld (DMEM_ERR_EN only)
module u_dmem
  import u_dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd
`ifdef DMEM_ERR_EN
  ,
  output logic        lsu_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  dmem_st_e         st;
  logic [LAT_W-1:0] cnt;
  logic [31:2]      a_q;
  logic [3:0]       we_q;
  logic [3:0]       re_q;
  logic [31:0]      wd_q;
  logic [31:0]      mask_q;
  logic [31:0]      ram_rd;
  logic [NLANE-1:0] ram_we;
  logic             oor;
  logic             wr_block;
  logic             fire;

  assign oor = |a_q[31:AW+2];

`ifdef DMEM_ERR_EN
  logic misal_q;
  logic err_q;
  assign wr_block = oor | misal_q;
  assign lsu_err  = err_q;
`else
  logic unused_lsb;
  assign unused_lsb = ^lsu_a[1:0];
  assign wr_block   = oor;
`endif

  // The RAM is touched only on the edge that enters RESP.
  assign fire   = (st == WAIT) && (cnt == '0);
  assign ram_we = wr_block ? '0 : we_q;

  // Both operands are registered on RESP entry, so lsu_rd holds its value.
  assign lsu_rd = ram_rd & mask_q;

  u_dmem_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk (clk),
    .rstn(rstn),
    .en  (fire),
    .addr(a_q[AW+1:2]),
    .we  (ram_we),
    .wd  (wd_q),
    .rd  (ram_rd)
  );

  // The WAIT counter is loaded with LAT (not LAT-1) because the capture
  // edge itself counts as one of the LAT+1 edges before RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st      <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      we_q    <= '0;
      wd_q    <= '0;
      re_q    <= '0;
      mask_q  <= '0;
      lsu_vld <= 1'b0;
`ifdef DMEM_ERR_EN
      misal_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      lsu_vld <= 1'b0;
`ifdef DMEM_ERR_EN
      err_q   <= 1'b0;
`endif
      case (st)
        IDLE: begin
          if ((|lsu_we) || (|lsu_re)) begin
            a_q  <= lsu_a[31:2];
            we_q <= lsu_we;
            wd_q <= lsu_wd;
            re_q <= lsu_re;
`ifdef DMEM_ERR_EN
            misal_q <= |lsu_a[1:0];
`endif
            cnt  <= LAT_W'(LAT);
            st   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            st      <= RESP;
            lsu_vld <= 1'b1;
            mask_q  <= oor ? '0 : lane_mask(re_q);
`ifdef DMEM_ERR_EN
            err_q   <= oor | misal_q;
`endif
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        RESP: begin
          st <= IDLE;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_u_dmem.sv
// tb_u_dmem
//   Self-checking bench for u_dmem. Three instances share clk/rstn:
//   index 0 has LAT=2, index 1 has LAT=0, index 2 has LAT=4 (DEPTH=1024).
//   Define DMEM_ERR_EN to also exercise lsu_err.
module tb_u_dmem;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [3:0]  re;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          sel;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [31:0] lsu_a   [3];
  logic [3:0]  lsu_we  [3];
  logic [31:0] lsu_wd  [3];
  logic [3:0]  lsu_re  [3];
  logic        lsu_vld [3];
  logic [31:0] lsu_rd  [3];
`ifdef DMEM_ERR_EN
  logic        lsu_err [3];
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[14];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    u_dmem #(
      .DEPTH(1024),
      .LAT  (g == 0 ? 2 : (g == 1 ? 0 : 4))
    ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .lsu_a  (lsu_a[g]),
      .lsu_we (lsu_we[g]),
      .lsu_wd (lsu_wd[g]),
      .lsu_re (lsu_re[g]),
      .lsu_vld(lsu_vld[g]),
      .lsu_rd (lsu_rd[g])
`ifdef DMEM_ERR_EN
      ,
      .lsu_err(lsu_err[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int latOf(input int sel);
    return (sel == 0) ? 2 : ((sel == 1) ? 0 : 4);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic dropReq(input int sel);
    lsu_a[sel]  = '0;
    lsu_we[sel] = '0;
    lsu_wd[sel] = '0;
    lsu_re[sel] = '0;
  endtask

  task automatic applyStimulus(input int sel, input vec_t v);
    exp_t e;
    @(negedge clk);
    lsu_a[sel]  = v.a;
    lsu_we[sel] = v.we;
    lsu_wd[sel] = v.wd;
    lsu_re[sel] = v.re;
    e.sel = sel;
    e.rd  = v.exp_rd;
    e.err = v.exp_err;
    e.lat = latOf(sel);
    sb.push_back(e);
  endtask

  // Waits (bounded) for the response, compares latency/data against the
  // scoreboard entry, confirms the pulse is one cycle, then drops the request.
  task automatic checkOutput(input string name);
    exp_t e;
    int   cycles;
    bit   got;
    e      = sb.pop_front();
    cycles = 0;
    got    = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (lsu_vld[e.sel]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no lsu_vld expected pulse", name);
    end else begin
      check32({name, " latency"}, cycles, e.lat + 1);
      check32({name, " rd"}, lsu_rd[e.sel], e.rd);
`ifdef DMEM_ERR_EN
      check32({name, " err"}, {31'd0, lsu_err[e.sel]}, {31'd0, e.err});
`endif
      @(posedge clk);
      @(negedge clk);
      check32({name, " single pulse"}, {31'd0, lsu_vld[e.sel]}, 32'd0);
    end
    dropReq(e.sel);
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 4'h0, 32'h0000_0000, 1'b0};
    tbl[1]  = '{32'h0000_0010, 4'h0, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{32'h0000_0010, 4'h2, 32'h0000_AB00, 4'h0, 32'h0000_0000, 1'b0};
    tbl[3]  = '{32'h0000_0010, 4'h0, 32'h0000_0000, 4'hF, 32'hDEAD_ABEF, 1'b0};
    tbl[4]  = '{32'h0000_0010, 4'h0, 32'h0000_0000, 4'h1, 32'h0000_00EF, 1'b0};
    tbl[5]  = '{32'h0000_0000, 4'hF, 32'h1122_3344, 4'h0, 32'h0000_0000, 1'b0};
    tbl[6]  = '{32'h0000_1000, 4'hF, 32'h1234_5678, 4'h0, 32'h0000_0000, 1'b1};
    tbl[7]  = '{32'h0000_0000, 4'h0, 32'h0000_0000, 4'hF, 32'h1122_3344, 1'b0};
    tbl[8]  = '{32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 4'h0, 32'h0000_0000, 1'b0};
    tbl[9]  = '{32'h0000_0040, 4'hC, 32'h5555_1234, 4'hF, 32'h5555_BEEF, 1'b0};
    tbl[10] = '{32'h0000_0040, 4'h0, 32'h0000_0000, 4'hA, 32'h5500_BE00, 1'b0};
    tbl[11] = '{32'h0000_0FFC, 4'hF, 32'h0F0F_0F0F, 4'hF, 32'h0F0F_0F0F, 1'b0};
    tbl[12] = '{32'h8000_0010, 4'h0, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    tbl[13] = '{32'h0000_0000, 4'h0, 32'h0000_0000, 4'h6, 32'h0022_3300, 1'b0};

    rstn = 1'b0;
    for (int s = 0; s < 3; s++) dropReq(s);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check32($sformatf("reset vld[%0d]", s), {31'd0, lsu_vld[s]}, 32'd0);
      check32($sformatf("reset rd[%0d]", s), lsu_rd[s], 32'd0);
`ifdef DMEM_ERR_EN
      check32($sformatf("reset err[%0d]", s), {31'd0, lsu_err[s]}, 32'd0);
`endif
    end
    rstn = 1'b1;

    // Table-driven vectors on the LAT=2 instance.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, tbl[i]);
      checkOutput($sformatf("vec%0d", i));
    end

`ifdef DMEM_ERR_EN
    // Misaligned write flags an error and leaves the word untouched.
    applyStimulus(0, '{32'h0000_0042, 4'hF, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1});
    checkOutput("misaligned write");
    applyStimulus(0, '{32'h0000_0040, 4'h0, 32'h0000_0000, 4'hF, 32'h5555_BEEF, 1'b0});
    checkOutput("after misaligned");
`endif

    // LAT=0 back-to-back: request held high, pulses expected in cycles 1,4,7.
    applyStimulus(1, '{32'h0000_0008, 4'hF, 32'hA5A5_5A5A, 4'h0, 32'h0000_0000, 1'b0});
    checkOutput("lat0 write");
    @(negedge clk);
    lsu_a[1]  = 32'h0000_0008;
    lsu_re[1] = 4'hF;
    for (int idx = 0; idx < 9; idx++) begin
      logic expv;
      @(posedge clk);
      @(negedge clk);
      expv = (idx == 1) || (idx == 4) || (idx == 7);
      check32($sformatf("b2b vld cycle %0d", idx), {31'd0, lsu_vld[1]}, {31'd0, expv});
      if (expv) check32($sformatf("b2b rd cycle %0d", idx), lsu_rd[1], 32'hA5A5_5A5A);
    end
    dropReq(1);

    // LAT=4 reset mid-operation: aborted write must not commit.
    applyStimulus(2, '{32'h0000_0020, 4'hF, 32'h1111_0000, 4'h0, 32'h0000_0000, 1'b0});
    checkOutput("lat4 prefill");
    @(negedge clk);
    lsu_a[2]  = 32'h0000_0020;
    lsu_we[2] = 4'hF;
    lsu_wd[2] = 32'hCAFE_F00D;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rstn = 1'b0;
    dropReq(2);
    #1;
    check32("midreset vld", {31'd0, lsu_vld[2]}, 32'd0);
    check32("midreset rd", lsu_rd[2], 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    begin
      bit saw;
      saw = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (lsu_vld[2]) saw = 1'b1;
      end
      check32("aborted op vld", {31'd0, saw}, 32'd0);
    end
    applyStimulus(2, '{32'h0000_0020, 4'h0, 32'h0000_0000, 4'hF, 32'h1111_0000, 1'b0});
    checkOutput("after abort read");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
